// File: rtl/btn_debounce_multi_if.sv
// Button conditioner bus: ce_tick and raw pins in, debounced level and strobes out.
interface btn_debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic                ce_tick;
    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] btn_level;
    logic [CHANNELS-1:0] btn_press;
    logic [CHANNELS-1:0] btn_release;
    logic [CHANNELS-1:0] btn_repeat;

    modport master (output ce_tick, btn_in,
                    input  btn_level, btn_press, btn_release, btn_repeat);
    modport slave  (input  ce_tick, btn_in,
                    output btn_level, btn_press, btn_release, btn_repeat);
endinterface

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: 2-flop sync, tick-based debounce,
// press/release strobes and optional auto-repeat, one lane instance per channel.
module btn_debounce_ch #(
    parameter int STABLE_TICKS = 8,
    parameter int ACTIVE_LOW   = 0,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce_tick_i,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);
    localparam int   DBW  = $clog2(STABLE_TICKS + 1);
    localparam logic IDLE = (ACTIVE_LOW != 0);
    localparam logic [DBW-1:0] DB_LAST = DBW'(STABLE_TICKS - 1);

    logic           sync1_q, sync2_q, s;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d, press_q, release_q;

    assign s = sync2_q ^ IDLE;

    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (ce_tick_i) begin
            if (s != level_q) begin
                if (db_cnt_q == DB_LAST) begin
                    level_d  = s;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end else begin
                db_cnt_d = '0;
            end
        end
    end

    // Strobes are cleared by reset, so a reset while pressed drops the level silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= IDLE;
            sync2_q   <= IDLE;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= pin_i;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= level_d & ~level_q;
            release_q <= ~level_d & level_q;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    generate
        if (REPEAT_EN != 0) begin : g_rep
            localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
            localparam int RW   = $clog2(RMAX + 1);
            localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
            localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
            localparam logic FIRST = 1'b0;
            localparam logic NEXT  = 1'b1;

            logic [RW-1:0] rp_cnt_q, rp_cnt_d;
            logic          phase_q, phase_d, rep_q, rep_d;

            // level_q is still 0 on the accepting edge, so the press strobe never coincides with a repeat.
            always_comb begin
                rp_cnt_d = rp_cnt_q;
                phase_d  = phase_q;
                rep_d    = 1'b0;
                if (!level_q) begin
                    rp_cnt_d = '0;
                    phase_d  = FIRST;
                end else if (ce_tick_i) begin
                    if (rp_cnt_q == ((phase_q == NEXT) ? RATE_LAST : DLY_LAST)) begin
                        rep_d    = 1'b1;
                        rp_cnt_d = '0;
                        phase_d  = NEXT;
                    end else begin
                        rp_cnt_d = rp_cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rp_cnt_q <= '0;
                    phase_q  <= FIRST;
                    rep_q    <= 1'b0;
                end else begin
                    rp_cnt_q <= rp_cnt_d;
                    phase_q  <= phase_d;
                    rep_q    <= rep_d;
                end
            end

            assign repeat_o = rep_q;
        end else begin : g_norep
            assign repeat_o = 1'b0;
        end
    endgenerate
endmodule

module btn_debounce_multi #(
    parameter int CHANNELS     = 4,
    parameter int STABLE_TICKS = 8,
    parameter int ACTIVE_LOW   = 0,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input logic                 clk,
    input logic                 rst_n,
    btn_debounce_multi_if.slave bus
);
    logic [CHANNELS-1:0] level, press, rel, rep;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            btn_debounce_ch #(
                .STABLE_TICKS(STABLE_TICKS),
                .ACTIVE_LOW  (ACTIVE_LOW),
                .REPEAT_EN   (REPEAT_EN),
                .REPEAT_DELAY(REPEAT_DELAY),
                .REPEAT_RATE (REPEAT_RATE)
            ) u_ch (
                .clk      (clk),
                .rst_n    (rst_n),
                .ce_tick_i(bus.ce_tick),
                .pin_i    (bus.btn_in[i]),
                .level_o  (level[i]),
                .press_o  (press[i]),
                .release_o(rel[i]),
                .repeat_o (rep[i])
            );
        end
    endgenerate

    assign bus.btn_level   = level;
    assign bus.btn_press   = press;
    assign bus.btn_release = rel;
    assign bus.btn_repeat  = rep;
endmodule
